// File: rtl/tc4_pkg.sv
// Shared constants, operation encoding and sizing helper for the
// two's complement accumulator slice.
package tc4_pkg;

    localparam int TC4_MIN = -8;
    localparam int TC4_MAX = 7;
    localparam int unsigned TC4_W = 4;

    typedef enum logic [1:0] {
        OP_NONE,
        OP_ADD,
        OP_SUB,
        OP_CLR
    } op_e;

    function automatic int unsigned db_cnt_w(input int unsigned db_cycles);
        return $clog2(db_cycles + 1);
    endfunction

endpackage

// File: rtl/tc4_accumulator_btn_conditioner.sv
// Raw pushbutton conditioning: 2-flop synchronizer, counting debouncer
// and rising-edge detector producing a one-cycle press pulse.
module btn_conditioner
    import tc4_pkg::*;
#(
    parameter int unsigned DB_CYCLES = 4
) (
    input  logic Clock,
    input  logic Reset,
    input  logic Raw,
    output logic Press
);

    localparam int unsigned CW = db_cnt_w(DB_CYCLES);

    logic          sync1;
    logic          s;
    logic          db;
    logic          db_q;
    logic [CW-1:0] cnt;

    always_ff @(posedge Clock) begin
        if (Reset) begin
            sync1 <= 1'b0;
            s     <= 1'b0;
            db    <= 1'b0;
            db_q  <= 1'b0;
            cnt   <= '0;
        end else begin
            sync1 <= Raw;
            s     <= sync1;
            db_q  <= db;
            // The edge that completes DB_CYCLES mismatching samples also flips db.
            if (s == db) begin
                cnt <= '0;
            end else if (cnt == CW'(DB_CYCLES - 1)) begin
                db  <= s;
                cnt <= '0;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

    assign Press = db & ~db_q;

endmodule

// File: rtl/tc4_accumulator.sv
// Signed 4-bit accumulator driven by conditioned Add/Sub/Clear buttons,
// with wrapping arithmetic and a sticky overflow flag.
module tc4_accumulator
    import tc4_pkg::*;
#(
    parameter int unsigned DB_CYCLES = 4
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic [TC4_W-1:0] B,
    input  logic             AddBtn,
    input  logic             SubBtn,
    input  logic             ClrBtn,
    output logic [TC4_W-1:0] N,
    output logic             Ovf,
    output logic             Done
);

    logic [TC4_W-1:0] b_meta;
    logic [TC4_W-1:0] b_sync;
    logic             add_p;
    logic             sub_p;
    logic             clr_p;
    op_e              op;
    logic [TC4_W:0]   r;

    btn_conditioner #(.DB_CYCLES(DB_CYCLES)) u_add (
        .Clock (Clock),
        .Reset (Reset),
        .Raw   (AddBtn),
        .Press (add_p)
    );

    btn_conditioner #(.DB_CYCLES(DB_CYCLES)) u_sub (
        .Clock (Clock),
        .Reset (Reset),
        .Raw   (SubBtn),
        .Press (sub_p)
    );

    btn_conditioner #(.DB_CYCLES(DB_CYCLES)) u_clr (
        .Clock (Clock),
        .Reset (Reset),
        .Raw   (ClrBtn),
        .Press (clr_p)
    );

    always_ff @(posedge Clock) begin
        if (Reset) begin
            b_meta <= '0;
            b_sync <= '0;
        end else begin
            b_meta <= B;
            b_sync <= b_meta;
        end
    end

    // Clear dominates; simultaneous Add and Sub cancel to no operation.
    always_comb begin
        op = OP_NONE;
        if (clr_p) begin
            op = OP_CLR;
        end else if (add_p && !sub_p) begin
            op = OP_ADD;
        end else if (sub_p && !add_p) begin
            op = OP_SUB;
        end
    end

    always_comb begin
        r = '0;
        if (op == OP_SUB) begin
            r = {N[TC4_W-1], N} - {b_sync[TC4_W-1], b_sync};
        end else begin
            r = {N[TC4_W-1], N} + {b_sync[TC4_W-1], b_sync};
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            N    <= '0;
            Ovf  <= 1'b0;
            Done <= 1'b0;
        end else begin
            case (op)
                OP_CLR: begin
                    N    <= '0;
                    Ovf  <= 1'b0;
                    Done <= 1'b1;
                end
                OP_ADD, OP_SUB: begin
                    N    <= r[TC4_W-1:0];
                    Done <= 1'b1;
                    if (r[TC4_W] != r[TC4_W-1]) begin
                        Ovf <= 1'b1;
                    end
                end
                default: begin
                    Done <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tc4_accumulator.sv
// Scoreboard bench for tc4_accumulator: directed button presses push the
// expected result and arrival cycle; a monitor checks every Done pulse.
module tb_tc4_accumulator;

    localparam int unsigned DB = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [3:0] b   = '0;
    logic       add_btn = 1'b0;
    logic       sub_btn = 1'b0;
    logic       clr_btn = 1'b0;
    logic [3:0] n;
    logic       ovf;
    logic       done;

    typedef struct {
        logic [3:0]  n;
        logic        ovf;
        int unsigned cyc;
    } exp_t;

    exp_t        sbq[$];
    int unsigned cyc    = 0;
    int unsigned checks = 0;
    int unsigned passed = 0;

    tc4_accumulator #(.DB_CYCLES(DB)) dut (
        .Clock  (clk),
        .Reset  (rst),
        .B      (b),
        .AddBtn (add_btn),
        .SubBtn (sub_btn),
        .ClrBtn (clr_btn),
        .N      (n),
        .Ovf    (ovf),
        .Done   (done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: every Done pulse must match the oldest expectation exactly.
    always @(negedge clk) begin
        if (done === 1'b1) begin
            exp_t e;
            checks++;
            if (sbq.size() == 0) begin
                $display("FAIL unexpected_done cyc=%0d N=%b Ovf=%b (no Done required)", cyc, n, ovf);
            end else begin
                e = sbq.pop_front();
                if (n !== e.n || ovf !== e.ovf || cyc != e.cyc)
                    $display("FAIL done_result got N=%b Ovf=%b cyc=%0d, required N=%b Ovf=%b cyc=%0d",
                             n, ovf, cyc, e.n, e.ovf, e.cyc);
                else
                    passed++;
            end
        end
    end

    task automatic check(input string name, input logic [4:0] act, input logic [4:0] req);
        checks++;
        if (act !== req) $display("FAIL %s got %b required %b", name, act, req);
        else passed++;
    endtask

    task automatic expect_done(input logic [3:0] en, input logic eo, input int unsigned at);
        exp_t e;
        e.n = en; e.ovf = eo; e.cyc = at;
        sbq.push_back(e);
    endtask

    // Clean press of the selected buttons; Done lands DB+2 edges after edge 1.
    task automatic press(input logic a, input logic s, input logic c,
                         input logic want, input logic [3:0] en, input logic eo);
        int unsigned e1;
        @(negedge clk);
        add_btn = a; sub_btn = s; clr_btn = c;
        e1 = cyc + 1;
        if (want) expect_done(en, eo, e1 + 2 + DB);
        repeat (DB + 4) @(negedge clk);
        add_btn = 1'b0; sub_btn = 1'b0; clr_btn = 1'b0;
        repeat (2 * DB + 6) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        int unsigned e0;

        do_reset();
        check("reset_state", {n, ovf}, 5'b0000_0);
        check("reset_done", {4'b0, done}, 5'b0);

        b = 4'b0011;
        press(1, 0, 0, 1, 4'b0011, 1'b0);
        press(1, 0, 0, 1, 4'b0110, 1'b0);
        press(1, 0, 0, 1, 4'b1001, 1'b1);   // 6+3 = 9 wraps to -7
        b = 4'b0001;
        press(0, 1, 0, 1, 4'b1000, 1'b1);   // sticky overflow
        press(0, 0, 1, 1, 4'b0000, 1'b0);

        b = 4'b1000;
        press(0, 1, 0, 1, 4'b1000, 1'b1);   // 0 - (-8) = +8 overflows
        press(0, 0, 1, 1, 4'b0000, 1'b0);
        b = 4'b0111;
        press(0, 1, 0, 1, 4'b1001, 1'b0);
        b = 4'b0000;
        press(1, 0, 0, 1, 4'b1001, 1'b0);   // add zero still pulses Done
        press(0, 1, 0, 1, 4'b1001, 1'b0);   // subtract zero likewise
        press(0, 0, 1, 1, 4'b0000, 1'b0);

        b = 4'b0010;
        press(1, 0, 0, 1, 4'b0010, 1'b0);
        b = 4'b0001;
        press(1, 1, 0, 0, 4'b0000, 1'b0);
        check("add_sub_cancel", {n, ovf}, 5'b0010_0);
        press(1, 0, 1, 1, 4'b0000, 1'b0);

        // Bouncy press: HHLLHHLLHH then steady high from index 8.
        @(negedge clk);
        e0 = cyc + 1;
        expect_done(4'b0001, 1'b0, e0 + 8 + 2 + DB);
        for (int i = 0; i < 10; i++) begin
            add_btn = ((i / 2) % 2 == 0);
            @(negedge clk);
        end
        add_btn = 1'b1;
        repeat (DB + 6) @(negedge clk);
        // Bouncy release must not produce a second press.
        for (int i = 0; i < 8; i++) begin
            add_btn = ((i / 2) % 2 == 1);
            @(negedge clk);
        end
        add_btn = 1'b0;
        repeat (2 * DB + 6) @(negedge clk);
        check("after_bounce", {n, ovf}, 5'b0001_0);

        // Glitch shorter than the debounce window.
        add_btn = 1'b1;
        repeat (DB - 1) @(negedge clk);
        add_btn = 1'b0;
        repeat (2 * DB + 6) @(negedge clk);
        check("glitch_ignored", {n, ovf}, 5'b0001_0);

        b = 4'b0100;
        press(1, 0, 0, 1, 4'b0101, 1'b0);

        // Reset in the middle of a pending Add debounce.
        @(negedge clk);
        add_btn = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        add_btn = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        check("reset_mid_debounce", {n, ovf}, 5'b0000_0);
        repeat (2 * DB + 6) @(negedge clk);
        check("no_update_after_reset", {n, ovf}, 5'b0000_0);

        // Add held through reset release counts as a fresh press.
        add_btn = 1'b1;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        expect_done(4'b0100, 1'b0, cyc + 1 + 2 + DB);
        repeat (DB + 6) @(negedge clk);
        add_btn = 1'b0;
        repeat (2 * DB + 6) @(negedge clk);
        check("held_through_reset", {n, ovf}, 5'b0100_0);

        while (sbq.size() != 0) begin
            exp_t e;
            e = sbq.pop_front();
            checks++;
            $display("FAIL missing_done got none required N=%b Ovf=%b at cyc=%0d", e.n, e.ovf, e.cyc);
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
